// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the console UART transmitter.
// UART_TX_PARITY_EN adds an even-parity bit and the PARITY state.
package uart_tx_pkg;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_t;

    localparam int unsigned FRAME_BITS = 11;
`else
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } tx_state_t;

    localparam int unsigned FRAME_BITS = 10;
`endif

    localparam int unsigned STAT_READY = 0;
    localparam int unsigned STAT_IDLE  = 1;
    localparam int unsigned STAT_OVF   = 7;

    function automatic int unsigned frame_clks(input int unsigned clks_per_bit);
        return FRAME_BITS * clks_per_bit;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the UART serializer; pointers wrap modulo DEPTH,
// occupancy kept in a separate counter (0..DEPTH).
module uart_tx_fifo
    import uart_tx_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           push,
    input  logic [7:0]                     push_data,
    input  logic                           pop,
    output logic [7:0]                     head_data,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(DEPTH+1)-1:0]     count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    logic          do_push;
    logic          do_pop;

    assign full      = (cnt == CW'(DEPTH));
    assign empty     = (cnt == '0);
    assign count     = cnt;
    assign head_data = mem[rd_ptr];
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_port.sv
// Console UART transmitter on the CPU bus: data register at BASE_ADDR,
// status at BASE_ADDR+1, 8N1 serializer (UART_TX_PARITY_EN adds even parity).
module uart_tx_port
    import uart_tx_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR    = 16'hF200,
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] address,
    input  logic        write_en,
    input  logic [7:0]  data_in,
    output logic [7:0]  data_out,
    output logic        txd,
    output logic        irq
);

    localparam logic [15:0] STAT_ADDR = BASE_ADDR + 16'd1;
    localparam int unsigned CNT_W     = $clog2(CLKS_PER_BIT);
    localparam int unsigned CW        = $clog2(FIFO_DEPTH + 1);

    tx_state_t      state, state_nx;
    logic [CNT_W-1:0] clk_cnt, clk_cnt_nx;
    logic [2:0]     bit_idx, bit_idx_nx;
    logic [7:0]     shifter, shifter_nx;
    logic           overflow, overflow_nx;
    logic           pop;
    logic           txd_c;
    logic           bit_end;

    logic           wr_data;
    logic           wr_stat;
    logic [7:0]     head_data;
    logic           fifo_full;
    logic           fifo_empty;
    logic [CW-1:0]  fifo_count;
    logic           tx_ready;
    logic           tx_idle;
    logic [7:0]     status;

    assign wr_data = write_en && (address == BASE_ADDR);
    assign wr_stat = write_en && (address == STAT_ADDR);

    // The FIFO judges fullness on its pre-edge count, so a same-cycle pop never frees a slot.
    uart_tx_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (wr_data),
        .push_data (data_in),
        .pop       (pop),
        .head_data (head_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign bit_end  = (clk_cnt == CNT_W'(CLKS_PER_BIT - 1));
    assign tx_ready = (fifo_count < CW'(FIFO_DEPTH));
    assign tx_idle  = fifo_empty && (state == ST_IDLE);
    assign irq      = !fifo_full && !overflow;
    assign txd      = txd_c;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state    <= ST_IDLE;
            clk_cnt  <= '0;
            bit_idx  <= '0;
            shifter  <= '0;
            overflow <= 1'b0;
        end else begin
            state    <= state_nx;
            clk_cnt  <= clk_cnt_nx;
            bit_idx  <= bit_idx_nx;
            shifter  <= shifter_nx;
            overflow <= overflow_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        clk_cnt_nx  = clk_cnt + 1'b1;
        bit_idx_nx  = bit_idx;
        shifter_nx  = shifter;
        overflow_nx = overflow;
        pop         = 1'b0;
        txd_c       = 1'b1;

        if (wr_data && fifo_full) begin
            overflow_nx = 1'b1;
        end else if (wr_stat && data_in[7]) begin
            overflow_nx = 1'b0;
        end

        case (state)
            ST_IDLE: begin
                clk_cnt_nx = '0;
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    shifter_nx = head_data;
                    state_nx   = ST_START;
                end
            end
            ST_START: begin
                txd_c = 1'b0;
                if (bit_end) begin
                    clk_cnt_nx = '0;
                    bit_idx_nx = '0;
                    state_nx   = ST_DATA;
                end
            end
            ST_DATA: begin
                txd_c = shifter[bit_idx];
                if (bit_end) begin
                    clk_cnt_nx = '0;
                    if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_nx = ST_PARITY;
`else
                        state_nx = ST_STOP;
`endif
                    end else begin
                        bit_idx_nx = bit_idx + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                txd_c = ^shifter;
                if (bit_end) begin
                    clk_cnt_nx = '0;
                    state_nx   = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                txd_c = 1'b1;
                if (bit_end) begin
                    clk_cnt_nx = '0;
                    // Back-to-back frames: reload straight into START with no idle gap.
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        shifter_nx = head_data;
                        state_nx   = ST_START;
                    end else begin
                        state_nx = ST_IDLE;
                    end
                end
            end
            default: begin
                clk_cnt_nx = '0;
                state_nx   = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        status             = '0;
        status[STAT_READY] = tx_ready;
        status[STAT_IDLE]  = tx_idle;
        status[STAT_OVF]   = overflow;
        data_out           = (address == STAT_ADDR) ? status : '0;
    end

endmodule
